ram_1port_bist: RTL and testbench
=================================

Name: ram_1port_bist

Overview:
- Built-in self-test initiator that drives the requester side of a single-port RAM (address, write strobe/data, read enable) and checks the read-back data.
- Runs a two-phase pattern test (incrementing, then inverted incrementing) over every address, comparing each returned word against the expected value.
- Reports pass/fail with first-failure capture.
- Sits between system control logic and a RAM_1Port instance. Used at power-up and on demand.

Parameters:
- WIDTH, 8, RAM data width in bits.
- DEPTH, 4, number of RAM words. Address width AW = $clog2(DEPTH).
- RD_TIMEOUT, 4, cycles without i_Rd_DV after the last read issue before a missing read is declared failed.

Ports:
- i_Clk  in  1  system clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous active-low reset
- i_Start  in  1  one-cycle start request, sampled only in IDLE
- o_Busy  out  1  high from the cycle after Start is accepted until DONE
- o_Done  out  1  one-cycle pulse when the test finishes
- o_Pass  out  1  result, valid from o_Done until the next accepted Start
- o_Fail_Addr  out  AW  address of the first mismatch
- o_Fail_Data  out  WIDTH  data read at the first mismatch (0 on timeout)
- o_Fail_Phase  out  1  phase of the first mismatch (0 = incrementing, 1 = inverted)
- o_Addr  out  AW  RAM address
- o_Wr_DV  out  1  RAM write strobe
- o_Wr_Data  out  WIDTH  RAM write data
- o_Rd_En  out  1  RAM read enable
- i_Rd_DV  in  1  RAM read-data valid (RAM responds one cycle after o_Rd_En)
- i_Rd_Data  in  WIDTH  RAM read data

Behaviour:
- Reset: all outputs 0. State IDLE, phase 0. Takes effect immediately (asynchronous), including mid-test; RAM strobes drop at once.
- Pattern: P0(a) = (a+1) truncated or zero-extended to WIDTH. P1(a) = ~P0(a).
- States:
  - IDLE: on i_Start go to WRITE. Clear o_Pass, fail capture, phase, and counters.
  - WRITE: one word per cycle. o_Wr_DV=1, o_Addr = 0..DEPTH-1, o_Wr_Data = Pphase(o_Addr). After address DEPTH-1 go to READ.
  - READ: o_Rd_En=1 for DEPTH consecutive cycles, o_Addr = 0..DEPTH-1. Then go to WAIT_RD.
  - WAIT_RD: wait until the check counter reaches DEPTH, then go to WRITE with phase 1 (if phase 0) or to DONE.
  - DONE: o_Done=1 for one cycle, o_Busy=0, then IDLE.
- Outputs outside WRITE/READ: o_Wr_DV and o_Rd_En are 0. o_Wr_Data is 0. o_Addr holds its last value.
- Checking (READ and WAIT_RD):
  - Check counter c starts at 0 per phase and increments on each i_Rd_DV.
  - Compare i_Rd_Data to Pphase(c).
  - Matching relies on in-order return. The RAM never reorders.
- Mismatch: capture c, i_Rd_Data and phase into the fail outputs (first failure only), then go straight to DONE with o_Pass=0. Remaining in-flight read data is ignored.
- Timeout: in WAIT_RD, RD_TIMEOUT consecutive cycles without i_Rd_DV is a fail with o_Fail_Addr=c, o_Fail_Data=0.
- i_Rd_DV outside READ/WAIT_RD is ignored.
- o_Pass=1 is set at DONE only if both phases complete with no mismatch and no timeout.
- i_Start while busy is ignored. No queuing.
- DEPTH=1: single write, single read per phase. The address counter wraps at DEPTH-1 (no power-of-two assumption).
- Nominal duration for a good RAM: 2*(2*DEPTH+2) cycles from accept to o_Done, ±1 cycle.

Optional Feature:
- Macro BIST_ERR_CNT_EN.
- Defined:
  - Adds output o_Err_Count, width $clog2(2*DEPTH+1).
  - A mismatch does not abort the test. Both phases run fully and every mismatching word increments o_Err_Count, saturating.
  - Timeout still aborts.
  - Fail capture still records the first failure only.
  - o_Pass = (count==0 and no timeout). Count is cleared on Start.
- Undefined: the port is absent and the first mismatch aborts, as described above.

Test Plan:
- Good RAM, DEPTH=4, pulse i_Start → writes 01,02,03,04 to addr 0..3, reads match, then FE,FD,FC,FB written and matched → one o_Done pulse, o_Pass=1, o_Busy low afterwards.
- RAM model with bit 7 stuck-at-1 at addr 1 → phase 0 reads 0x82 at addr 1 → o_Pass=0, o_Fail_Addr=1, o_Fail_Data=0x82, o_Fail_Phase=0, no phase-1 writes issued.
- RAM model that never asserts i_Rd_DV → o_Done after RD_TIMEOUT idle cycles in WAIT_RD, o_Pass=0, o_Fail_Addr=0, o_Fail_Data=0.
- i_Start pulsed during WRITE → ignored, single run completes. A second Start after o_Done reruns and clears the previous fail capture.
- Assert i_Rst_L=0 during READ of addr 2 → o_Rd_En, o_Busy, o_Pass drop in the same cycle (asynchronously). After release, IDLE with no RAM activity until the next Start.
- With BIST_ERR_CNT_EN: addr 1 bit 7 stuck-at-1 plus addr 3 bit 0 stuck-at-0 → both phases complete, o_Err_Count=2, o_Fail_Addr=1, o_Fail_Phase=0, o_Pass=0.

Source files
------------

// File: rtl/ram_1port_bist.sv
`default_nettype none
// =============================================================================
// Module   : ram_1port_bist
// Purpose  : Built-in self-test initiator for a single-port RAM. It writes an
//            incrementing pattern P0(a) = a+1 to every address and reads it
//            back in order, checking each word. It then repeats the pass with
//            the inverted pattern P1(a) = ~P0(a). The result is pass/fail,
//            with the address, data and phase of the first failure captured.
//
// Ports    : i_Clk        - system clock, rising edge
//            i_Rst_L      - asynchronous active-low reset
//            i_Start      - start request, sampled only while idle
//            o_Busy       - test in progress
//            o_Done       - one-cycle completion pulse
//            o_Pass       - result, valid from o_Done until the next start
//            o_Fail_Addr  - address of the first mismatch / missing read
//            o_Fail_Data  - data read at the first mismatch (0 on timeout)
//            o_Fail_Phase - pattern phase of the first failure
//            o_Err_Count  - saturating mismatch count (BIST_ERR_CNT_EN only)
//            o_Addr       - RAM address
//            o_Wr_DV      - RAM write strobe
//            o_Wr_Data    - RAM write data
//            o_Rd_En      - RAM read enable
//            i_Rd_DV      - RAM read data valid, one cycle after o_Rd_En
//            i_Rd_Data    - RAM read data
//
// Options  : BIST_ERR_CNT_EN - when defined, a mismatch does not abort the
//            test. Both phases run to completion, and every mismatching word
//            is counted on o_Err_Count. A read timeout still aborts the test.
//
// Revision : 1.0 - initial release
// =============================================================================
module ram_1port_bist #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 4,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
`ifdef BIST_ERR_CNT_EN
    ,
    localparam int EW        = $clog2(2 * DEPTH + 1)
`endif
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Start,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [AW-1:0]    o_Fail_Addr,
    output logic [WIDTH-1:0] o_Fail_Data,
    output logic             o_Fail_Phase,
`ifdef BIST_ERR_CNT_EN
    output logic [EW-1:0]    o_Err_Count,
`endif
    output logic [AW-1:0]    o_Addr,
    output logic             o_Wr_DV,
    output logic [WIDTH-1:0] o_Wr_Data,
    output logic             o_Rd_En,
    input  logic             i_Rd_DV,
    input  logic [WIDTH-1:0] i_Rd_Data
);

    // The check counter must be able to hold DEPTH itself ("all words seen").
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] c_ALL_READ  = CW'(DEPTH);
    localparam logic [TW-1:0] c_TMO_LAST  = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_WAIT_RD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [AW-1:0]    r_addr;
    logic             r_phase;
    logic [CW-1:0]    r_chk;
    logic [TW-1:0]    r_tmo;
    logic             r_pass;
    logic             r_failed;
    logic [AW-1:0]    r_fail_addr;
    logic [WIDTH-1:0] r_fail_data;
    logic             r_fail_phase;
`ifdef BIST_ERR_CNT_EN
    logic [EW-1:0]    r_err_cnt;
`endif

    logic             w_addr_last;
    logic             w_checks_done;
    logic             w_check;
    logic             w_mismatch;
    logic             w_abort;
    logic             w_timeout;
    logic [WIDTH-1:0] w_expect;
    logic [WIDTH-1:0] w_wr_pattern;

    // P0(a) = a+1 truncated/zero-extended to WIDTH; P1(a) = ~P0(a).
    function automatic logic [WIDTH-1:0] f_pattern(input logic phase, input logic [31:0] idx);
        logic [WIDTH-1:0] v;
        v = WIDTH'(idx + 32'd1);
        return phase ? ~v : v;
    endfunction

    assign w_addr_last   = (r_addr == c_LAST_ADDR);
    assign w_checks_done = (r_chk == c_ALL_READ);
    assign w_expect      = f_pattern(r_phase, 32'(r_chk));
    assign w_wr_pattern  = f_pattern(r_phase, 32'(r_addr));

    // Read data is matched purely by arrival order; the RAM never reorders.
    assign w_check    = i_Rd_DV && ((r_state == S_READ) || (r_state == S_WAIT_RD)) && !w_checks_done;
    assign w_mismatch = w_check && (i_Rd_Data != w_expect);
    assign w_timeout  = (r_state == S_WAIT_RD) && !i_Rd_DV && !w_checks_done && (r_tmo == c_TMO_LAST);

`ifdef BIST_ERR_CNT_EN
    assign w_abort = 1'b0;
`else
    assign w_abort = w_mismatch;
`endif

    assign o_Addr       = r_addr;
    assign o_Pass       = r_pass;
    assign o_Fail_Addr  = r_fail_addr;
    assign o_Fail_Data  = r_fail_data;
    assign o_Fail_Phase = r_fail_phase;
`ifdef BIST_ERR_CNT_EN
    assign o_Err_Count  = r_err_cnt;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RAM strobes are decoded from the state so an asynchronous reset drops
    // them immediately.
    always_comb begin
        w_next_state = r_state;
        o_Busy       = 1'b0;
        o_Done       = 1'b0;
        o_Wr_DV      = 1'b0;
        o_Rd_En      = 1'b0;
        o_Wr_Data    = '0;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                o_Busy    = 1'b1;
                o_Wr_DV   = 1'b1;
                o_Wr_Data = w_wr_pattern;
                if (w_addr_last) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                o_Busy  = 1'b1;
                o_Rd_En = 1'b1;
                if (w_abort) begin
                    w_next_state = S_DONE;
                end else if (w_addr_last) begin
                    w_next_state = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                o_Busy = 1'b1;
                if (w_checks_done) begin
                    w_next_state = r_phase ? S_DONE : S_WRITE;
                end else if (w_abort || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_Done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_addr       <= '0;
            r_phase      <= 1'b0;
            r_chk        <= '0;
            r_tmo        <= '0;
            r_pass       <= 1'b0;
            r_failed     <= 1'b0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_fail_phase <= 1'b0;
`ifdef BIST_ERR_CNT_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_addr       <= '0;
                        r_phase      <= 1'b0;
                        r_chk        <= '0;
                        r_tmo        <= '0;
                        r_pass       <= 1'b0;
                        r_failed     <= 1'b0;
                        r_fail_addr  <= '0;
                        r_fail_data  <= '0;
                        r_fail_phase <= 1'b0;
`ifdef BIST_ERR_CNT_EN
                        r_err_cnt    <= '0;
`endif
                    end
                end
                // Address restarts at 0 for the read sweep; after the read
                // sweep it is left at DEPTH-1 so o_Addr holds its last value.
                S_WRITE: begin
                    r_addr <= w_addr_last ? '0 : r_addr + AW'(1);
                end
                S_READ: begin
                    if (!w_addr_last) begin
                        r_addr <= r_addr + AW'(1);
                    end
                end
                S_WAIT_RD: begin
                    if (w_checks_done) begin
                        r_chk <= '0;
                        r_tmo <= '0;
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            r_addr  <= '0;
                        end else begin
                            r_pass <= ~r_failed;
                        end
                    end else if (i_Rd_DV) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                end
            endcase

            if (w_check) begin
                r_chk <= r_chk + CW'(1);
                if (w_mismatch) begin
                    r_failed <= 1'b1;
                    if (!r_failed) begin
                        r_fail_addr  <= AW'(r_chk);
                        r_fail_data  <= i_Rd_Data;
                        r_fail_phase <= r_phase;
                    end
`ifdef BIST_ERR_CNT_EN
                    if (r_err_cnt != '1) begin
                        r_err_cnt <= r_err_cnt + EW'(1);
                    end
`endif
                end
            end

            if (w_timeout) begin
                r_failed <= 1'b1;
                if (!r_failed) begin
                    r_fail_addr  <= AW'(r_chk);
                    r_fail_data  <= '0;
                    r_fail_phase <= r_phase;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_1port_bist.sv
`default_nettype none
// =============================================================================
// Module   : tb_ram_1port_bist
// Purpose  : Self-checking bench for ram_1port_bist. A behavioural RAM model
//            with per-address stuck-at masks and a "no read valid" mode sits
//            on the RAM side. Expected writes and completion results are
//            queued when each test is launched. A monitor pops and compares
//            them whenever the DUT strobes a write or pulses o_Done.
// Revision : 1.0 - initial release
// =============================================================================
module tb_ram_1port_bist;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 4;
    localparam int RD_TIMEOUT = 4;
    localparam int AW         = 2;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        logic             pass;
        logic [AW-1:0]    faddr;
        logic [WIDTH-1:0] fdata;
        logic             fphase;
        int               errs;
    } res_t;

    logic             r_Clk = 1'b0;
    logic             r_Rst_L;
    logic             r_Start;
    logic             w_Busy;
    logic             w_Done;
    logic             w_Pass;
    logic [AW-1:0]    w_Fail_Addr;
    logic [WIDTH-1:0] w_Fail_Data;
    logic             w_Fail_Phase;
`ifdef BIST_ERR_CNT_EN
    logic [3:0]       w_Err_Count;
`endif
    logic [AW-1:0]    w_Addr;
    logic             w_Wr_DV;
    logic [WIDTH-1:0] w_Wr_Data;
    logic             w_Rd_En;
    logic             r_Rd_DV;
    logic [WIDTH-1:0] r_Rd_Data;

    // Hand-computed patterns: P0 = addr+1, P1 = ~P0.
    logic [WIDTH-1:0] c_P0 [DEPTH] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [WIDTH-1:0] c_P1 [DEPTH] = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};

    logic [WIDTH-1:0] mem    [DEPTH];
    logic [WIDTH-1:0] stuck1 [DEPTH];
    logic [WIDTH-1:0] stuck0 [DEPTH];
    logic             nodv;

    wr_t  wr_q [$];
    res_t res_q[$];
    wr_t  m_wr;
    res_t m_res;

    int checks   = 0;
    int failures = 0;

    always #5 r_Clk = ~r_Clk;

    ram_1port_bist #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_dut (
        .i_Clk        (r_Clk),
        .i_Rst_L      (r_Rst_L),
        .i_Start      (r_Start),
        .o_Busy       (w_Busy),
        .o_Done       (w_Done),
        .o_Pass       (w_Pass),
        .o_Fail_Addr  (w_Fail_Addr),
        .o_Fail_Data  (w_Fail_Data),
        .o_Fail_Phase (w_Fail_Phase),
`ifdef BIST_ERR_CNT_EN
        .o_Err_Count  (w_Err_Count),
`endif
        .o_Addr       (w_Addr),
        .o_Wr_DV      (w_Wr_DV),
        .o_Wr_Data    (w_Wr_Data),
        .o_Rd_En      (w_Rd_En),
        .i_Rd_DV      (r_Rd_DV),
        .i_Rd_Data    (r_Rd_Data)
    );

    // RAM model: one-cycle read latency, stuck-at faults applied on read.
    always @(posedge r_Clk) begin
        if (w_Wr_DV) begin
            mem[w_Addr] <= w_Wr_Data;
        end
        r_Rd_DV   <= w_Rd_En && !nodv;
        r_Rd_Data <= (mem[w_Addr] | stuck1[w_Addr]) & ~stuck0[w_Addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: consumes expected writes and results as the DUT produces them.
    always @(negedge r_Clk) begin
        if (r_Rst_L) begin
            if (w_Wr_DV) begin
                check("wr_expected", 32'(wr_q.size() != 0), 32'h1);
                if (wr_q.size() != 0) begin
                    m_wr = wr_q.pop_front();
                    check("wr_addr", 32'(w_Addr), 32'(m_wr.addr));
                    check("wr_data", 32'(w_Wr_Data), 32'(m_wr.data));
                end
            end
            if (w_Done) begin
                check("done_expected", 32'(res_q.size() != 0), 32'h1);
                if (res_q.size() != 0) begin
                    m_res = res_q.pop_front();
                    check("done_pass", 32'(w_Pass), 32'(m_res.pass));
                    check("done_fail_addr", 32'(w_Fail_Addr), 32'(m_res.faddr));
                    check("done_fail_data", 32'(w_Fail_Data), 32'(m_res.fdata));
                    check("done_fail_phase", 32'(w_Fail_Phase), 32'(m_res.fphase));
                    check("done_busy_low", 32'(w_Busy), 32'h0);
`ifdef BIST_ERR_CNT_EN
                    check("done_err_count", 32'(w_Err_Count), 32'(m_res.errs));
`endif
                end
            end
        end
    end

    task automatic push_writes(input int phases);
        for (int ph = 0; ph < phases; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr_q.push_back('{addr: AW'(a), data: (ph == 0) ? c_P0[a] : c_P1[a]});
            end
        end
    endtask

    task automatic push_res(input logic pass, input logic [AW-1:0] fa,
                            input logic [WIDTH-1:0] fd, input logic fp, input int errs);
        res_q.push_back('{pass: pass, faddr: fa, fdata: fd, fphase: fp, errs: errs});
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            stuck1[a] = '0;
            stuck0[a] = '0;
        end
        nodv = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic start_pulse();
        r_Start = 1'b1;
        @(negedge r_Clk);
        r_Start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        while (cyc < max && !w_Done) begin
            @(negedge r_Clk);
            cyc++;
        end
        check("done_within_bound", 32'(w_Done), 32'h1);
    endtask

    task automatic drain_and_check(input string name, input int n);
        repeat (n) @(negedge r_Clk);
        check({name, "_wr_q_empty"}, 32'(wr_q.size()), 32'h0);
        check({name, "_res_q_empty"}, 32'(res_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        int  found;
        int  activity;

        clear_faults();
        r_Rst_L = 1'b0;
        r_Start = 1'b0;
        repeat (3) @(negedge r_Clk);

        // Reset state: every output low.
        check("rst_busy", 32'(w_Busy), 32'h0);
        check("rst_done", 32'(w_Done), 32'h0);
        check("rst_pass", 32'(w_Pass), 32'h0);
        check("rst_wr_dv", 32'(w_Wr_DV), 32'h0);
        check("rst_rd_en", 32'(w_Rd_En), 32'h0);
        check("rst_addr", 32'(w_Addr), 32'h0);
        check("rst_wr_data", 32'(w_Wr_Data), 32'h0);
        check("rst_fail_addr", 32'(w_Fail_Addr), 32'h0);
        check("rst_fail_data", 32'(w_Fail_Data), 32'h0);
        check("rst_fail_phase", 32'(w_Fail_Phase), 32'h0);
        r_Rst_L = 1'b1;
        repeat (2) @(negedge r_Clk);

        // Good RAM: 01..04 then FE..FB, pass. Nominal 20 cycles, +/-1.
        push_writes(2);
        push_res(1'b1, 2'd0, 8'h00, 1'b0, 0);
        start_pulse();
        check("good_busy_after_accept", 32'(w_Busy), 32'h1);
        wait_done(40, cyc);
        check("good_duration_window", 32'(cyc >= 19 && cyc <= 21), 32'h1);
        @(negedge r_Clk);
        check("good_done_one_cycle", 32'(w_Done), 32'h0);
        check("good_busy_after_done", 32'(w_Busy), 32'h0);
        check("good_pass_held", 32'(w_Pass), 32'h1);
        drain_and_check("good", 5);

        // Bit 7 stuck-at-1 at address 1: phase 0 reads 0x82 there.
        stuck1[1] = 8'h80;
`ifdef BIST_ERR_CNT_EN
        push_writes(2);
        push_res(1'b0, 2'd1, 8'h82, 1'b0, 1);
`else
        push_writes(1);
        push_res(1'b0, 2'd1, 8'h82, 1'b0, 0);
`endif
        start_pulse();
        wait_done(40, cyc);
        drain_and_check("stuck", 8);
        clear_faults();

        // Start during WRITE is ignored; this rerun clears the old capture.
        push_writes(2);
        push_res(1'b1, 2'd0, 8'h00, 1'b0, 0);
        start_pulse();
        r_Start = 1'b1;
        @(negedge r_Clk);
        r_Start = 1'b0;
        check("rerun_busy_during_write", 32'(w_Busy), 32'h1);
        wait_done(40, cyc);
        drain_and_check("rerun", 10);

        // RAM never returns data: timeout after 4+4 issue cycles + 4 idle.
        nodv = 1'b1;
        push_writes(1);
        push_res(1'b0, 2'd0, 8'h00, 1'b0, 0);
        start_pulse();
        wait_done(40, cyc);
        check("timeout_cycles", 32'(cyc), 32'd12);
        drain_and_check("timeout", 5);
        clear_faults();

        // Asynchronous reset while reading address 2.
        push_writes(1);
        start_pulse();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge r_Clk);
            if (w_Rd_En && w_Addr == 2'd2) found = 1;
        end
        check("arst_reached_read2", 32'(found), 32'h1);
        #1 r_Rst_L = 1'b0;
        #1;
        check("arst_rd_en_drop", 32'(w_Rd_En), 32'h0);
        check("arst_busy_drop", 32'(w_Busy), 32'h0);
        check("arst_pass_low", 32'(w_Pass), 32'h0);
        check("arst_addr_zero", 32'(w_Addr), 32'h0);
        repeat (2) @(negedge r_Clk);
        r_Rst_L = 1'b1;
        activity = 0;
        repeat (10) begin
            @(negedge r_Clk);
            if (w_Wr_DV || w_Rd_En || w_Busy || w_Done) activity++;
        end
        check("arst_idle_no_activity", 32'(activity), 32'h0);
        check("arst_wr_q_empty", 32'(wr_q.size()), 32'h0);

`ifdef BIST_ERR_CNT_EN
        // Addr 1 bit 7 stuck-1 (fails phase 0: 0x82), addr 3 bit 0 stuck-0
        // (fails phase 1: 0xFA). Both phases complete, two errors counted.
        stuck1[1] = 8'h80;
        stuck0[3] = 8'h01;
        push_writes(2);
        push_res(1'b0, 2'd1, 8'h82, 1'b0, 2);
        start_pulse();
        wait_done(40, cyc);
        drain_and_check("errcnt", 5);
        clear_faults();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
